// File: rtl/seq_pattern_gen_pkg.sv
// Shared definitions for the serial pattern generator and the recognizer-side bench.
// Holds the FSM state encodings and the default widths.
package seq_pattern_gen_pkg;
  localparam int DEF_MAX_LEN = 8;
  localparam int DEF_LEN_W   = 4;
  localparam int DEF_CNT_W   = 4;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = IDLE,
    ST_SEND = SEND,
    ST_GAP  = GAP
  } state_e;
endpackage

// File: rtl/seq_pattern_gen_if.sv
// Request/serial-output bundle between a pattern source and seq_pattern_gen.
interface seq_pattern_gen_if #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4,
  parameter int CNT_W   = 4
) ();
  logic               start;
  logic [MAX_LEN-1:0] pat;
  logic [LEN_W-1:0]   len;
  logic [CNT_W-1:0]   reps;
  logic [CNT_W-1:0]   gap;
  logic               out;
  logic               valid;
  logic               busy;
  logic               done;

  modport master (output start, pat, len, reps, gap,
                  input  out, valid, busy, done);
  modport slave  (input  start, pat, len, reps, gap,
                  output out, valid, busy, done);
endinterface

// File: rtl/seq_pattern_gen_shifter.sv
// Loadable pattern register with a bit-index down-counter; presents the bit
// currently selected and flags when the index has reached bit 0.
module seq_bit_shifter #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [MAX_LEN-1:0] pat,
  input  logic [LEN_W-1:0]   len,
  input  logic               rewind,
  input  logic               advance,
  output logic               cur_bit,
  output logic               last_bit
);
  logic [MAX_LEN-1:0] pat_q;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   idx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pat_q <= '0;
      len_q <= '0;
      idx   <= '0;
    end else if (load) begin
      pat_q <= pat;
      len_q <= len;
      idx   <= (len == '0) ? '0 : len - LEN_W'(1);
    end else if (rewind) begin
      idx <= (len_q == '0) ? '0 : len_q - LEN_W'(1);
    end else if (advance && idx != '0) begin
      idx <= idx - LEN_W'(1);
    end
  end

  // mask select keeps the index width independent of the pattern width
  assign cur_bit  = |(pat_q & (MAX_LEN'(1) << idx));
  assign last_bit = (idx == '0);
endmodule

// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter: sends a latched pattern MSB-first, reps times,
// with gap idle cycles between repetitions, then pulses done.
module seq_pattern_gen
  import seq_pattern_gen_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int LEN_W   = DEF_LEN_W,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic          clk,
  input  logic          reset,
  seq_pattern_gen_if.slave bus
);
  state_e           state, state_nx;
  logic [CNT_W-1:0] rep_cnt, gap_cnt, gap_q;
  logic [LEN_W-1:0] len_c;
  logic             done_q, fin;
  logic             ld, rew, adv;
  logic             cur_bit, last_bit;

  assign len_c = (bus.len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : bus.len;

  seq_bit_shifter #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) u_shift (
    .clk     (clk),
    .reset   (reset),
    .load    (ld),
    .pat     (bus.pat),
    .len     (len_c),
    .rewind  (rew),
    .advance (adv),
    .cur_bit (cur_bit),
    .last_bit(last_bit)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    ld       = 1'b0;
    rew      = 1'b0;
    adv      = 1'b0;
    fin      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          ld = 1'b1;
          if (len_c != '0 && bus.reps != '0) state_nx = ST_SEND;
          else                               fin      = 1'b1;
        end
      end
      ST_SEND: begin
        if (last_bit) begin
          if (rep_cnt > CNT_W'(1)) begin
            rew = 1'b1;
            if (gap_q != '0) state_nx = ST_GAP;
          end else begin
            state_nx = ST_IDLE;
            fin      = 1'b1;
          end
        end else begin
          adv = 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_cnt <= CNT_W'(1)) state_nx = ST_SEND;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // rep_cnt counts repetitions still owed including the one on the wire
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rep_cnt <= '0;
      gap_q   <= '0;
      gap_cnt <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= fin;
      if (state == ST_IDLE && bus.start) begin
        rep_cnt <= bus.reps;
        gap_q   <= bus.gap;
      end else if (state == ST_SEND && last_bit && rep_cnt != '0) begin
        rep_cnt <= rep_cnt - CNT_W'(1);
      end
      if (state == ST_SEND && state_nx == ST_GAP)
        gap_cnt <= gap_q;
      else if (state == ST_GAP && gap_cnt != '0)
        gap_cnt <= gap_cnt - CNT_W'(1);
    end
  end

  assign bus.valid = (state == ST_SEND);
  assign bus.out   = bus.valid & cur_bit;
  assign bus.busy  = (state != ST_IDLE);
  assign bus.done  = done_q;
endmodule

// File: tb/tb_seq_pattern_gen.sv
// Scoreboard bench for seq_pattern_gen: expected bits and busy lengths are
// queued at request time and retired as the serial stream appears.
module tb_seq_pattern_gen;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  seq_pattern_gen_if #(.MAX_LEN(8), .LEN_W(4), .CNT_W(4)) bus ();
  seq_pattern_gen #(.MAX_LEN(8), .LEN_W(4), .CNT_W(4)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int   n_chk = 0;
  int   n_fail = 0;
  logic exp_bits[$];
  int   exp_busy[$];
  bit   mon_en = 1'b0;
  int   busy_cnt = 0;
  int   done_cnt = 0;
  int   hits = 0;
  logic [2:0] hist = 3'b000;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!mon_en) begin
      busy_cnt = 0;
      hist     = 3'b000;
      exp_bits.delete();
      exp_busy.delete();
    end else begin
      if (bus.valid) begin
        hist = {hist[1:0], bus.out};
        if (hist == 3'b101) hits++;
        if (exp_bits.size() == 0) chk("extra_bit", 1, 0);
        else                      chk("bit", int'(bus.out), int'(exp_bits.pop_front()));
      end else begin
        chk("idle_out", int'(bus.out), 0);
      end
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        done_cnt++;
        hist = 3'b000;
        chk("done_busy", int'(bus.busy), 0);
        if (exp_busy.size() == 0) chk("spurious_done", 1, 0);
        else                      chk("busy_cycles", busy_cnt, exp_busy.pop_front());
        busy_cnt = 0;
      end
    end
  end

  task automatic push_exp(input logic [7:0] p, input int l, input int r, input int g);
    int lc;
    lc = (l > 8) ? 8 : l;
    if (lc != 0 && r != 0) begin
      for (int k = 0; k < r; k++)
        for (int i = lc - 1; i >= 0; i--) exp_bits.push_back(p[i]);
      exp_busy.push_back(lc * r + g * (r - 1));
    end else begin
      exp_busy.push_back(0);
    end
  endtask

  task automatic run_xfer(input logic [7:0] p, input int l, input int r, input int g,
                          input bit poke);
    int  lc, d0;
    bit  got;
    lc = (l > 8) ? 8 : l;
    push_exp(p, l, r, g);
    d0 = done_cnt;
    @(negedge clk);
    bus.pat = p; bus.len = 4'(l); bus.reps = 4'(r); bus.gap = 4'(g); bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("lat_valid", int'(bus.valid), (lc != 0 && r != 0) ? 1 : 0);
    if (lc != 0 && r != 0) chk("first_bit", int'(bus.out), int'(p[lc-1]));
    else                   chk("zero_done", int'(bus.done), 1);
    got = bus.done;
    if (poke && !got) begin
      bus.pat = ~p; bus.len = 4'd1; bus.reps = 4'd1; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      got = bus.done;
    end
    for (int c = 0; c < 300 && !got; c++) begin
      @(negedge clk);
      got = bus.done;
    end
    chk("done_seen", int'(got), 1);
    @(negedge clk);
    chk("done_pulse", done_cnt - d0, 1);
    chk("done_low", int'(bus.done), 0);
    chk("bits_left", exp_bits.size(), 0);
  endtask

  initial begin
    int h0, seen;
    bit prev_done;
    bus.start = 1'b0; bus.pat = '0; bus.len = '0; bus.reps = '0; bus.gap = '0;
    repeat (2) @(negedge clk);
    chk("rst_out", int'(bus.out), 0);
    chk("rst_valid", int'(bus.valid), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    reset = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;

    run_xfer(8'b101, 3, 1, 0, 1'b0);
    h0 = hits;
    run_xfer(8'b101, 3, 2, 0, 1'b0);
    chk("recog_hits", hits - h0, 2);
    run_xfer(8'b11, 2, 3, 2, 1'b1);
    run_xfer(8'b01101, 5, 2, 3, 1'b0);
    run_xfer(8'b101, 0, 3, 1, 1'b0);
    run_xfer(8'b101, 3, 0, 1, 1'b0);

    // start held high: three 8-bit transfers chained through their done cycles
    for (int k = 0; k < 3; k++) push_exp(8'hA5, 12, 1, 0);
    @(negedge clk);
    bus.pat = 8'hA5; bus.len = 4'd12; bus.reps = 4'd1; bus.gap = 4'd0; bus.start = 1'b1;
    seen = 0;
    prev_done = 1'b0;
    for (int c = 0; c < 200 && seen < 3; c++) begin
      @(negedge clk);
      if (prev_done) chk("b2b_valid", int'(bus.valid), 1);
      prev_done = bus.done;
      if (bus.done) begin
        seen++;
        if (seen == 3) bus.start = 1'b0;
      end
    end
    chk("held_dones", seen, 3);
    @(negedge clk);
    chk("held_idle", int'(bus.busy), 0);
    chk("held_bits_left", exp_bits.size(), 0);

    // asynchronous reset in the middle of a transfer
    mon_en = 1'b0;
    @(negedge clk);
    bus.pat = 8'hFF; bus.len = 4'd8; bus.reps = 4'd2; bus.gap = 4'd1; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    chk("pre_rst_valid", int'(bus.valid), 1);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("arst_out", int'(bus.out), 0);
    chk("arst_valid", int'(bus.valid), 0);
    chk("arst_busy", int'(bus.busy), 0);
    chk("arst_done", int'(bus.done), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", int'(bus.busy), 0);
    mon_en = 1'b1;
    run_xfer(8'b1001, 4, 1, 0, 1'b0);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "timeout");
  end
endmodule
